// File: rtl/spi_link_pkg.sv
// Shared types and constants for the SPI link arbiter slice.
package spi_link_pkg;

   localparam int GNT_W   = 2;
   localparam int MAX_REQ = 4;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SETUP = 3'd1,
      ST_XFER  = 3'd2,
      ST_HOLD  = 3'd3,
      ST_GAP   = 3'd4
   } state_t;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/spi_rr_picker.sv
// Combinational round-robin select: first requesting index after rr_ptr, with wrap.
module spi_rr_picker
   import spi_link_pkg::*;
#(
   parameter int NUM_REQ = 2
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [GNT_W-1:0]   rr_ptr,
   output logic [GNT_W-1:0]   winner,
   output logic               any_req
);

   // Scan offsets from farthest to nearest so the nearest hit is written last.
   always_comb begin
      winner  = '0;
      any_req = |req;
      for (int off = NUM_REQ; off >= 1; off--) begin
         for (int j = 0; j < NUM_REQ; j++) begin
            if (req[j] && (j == ((int'(rr_ptr) + off) % NUM_REQ)))
               winner = GNT_W'(j);
         end
      end
   end

endmodule

// File: rtl/spi_link_arbiter.sv
// Shares one SPI byte channel among NUM_REQ requesters; owns chip selects and
// CS setup/hold/gap timing. An owner keeps the channel until its last byte is accepted.
module spi_link_arbiter
   import spi_link_pkg::*;
#(
   parameter int NUM_REQ  = 2,
   parameter int CS_SETUP = 2,
   parameter int CS_HOLD  = 2,
   parameter int CS_GAP   = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [8*NUM_REQ-1:0] req_data,
   input  logic [NUM_REQ-1:0]   req_valid,
   input  logic [NUM_REQ-1:0]   req_last,
   output logic [NUM_REQ-1:0]   req_ready,
   output logic [7:0]           out_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [NUM_REQ-1:0]   cs_n,
   output logic [GNT_W-1:0]     gnt_id,
   output logic                 busy
);

   localparam int CNT_W = $clog2(max3(CS_SETUP, CS_HOLD, CS_GAP) + 1);

   state_t             state;
   logic [CNT_W-1:0]   cnt;
   logic [GNT_W-1:0]   rr_ptr;
   logic [GNT_W-1:0]   winner;
   logic               any_req;
   logic [7:0]         sel_data;
   logic               sel_valid;
   logic               sel_last;
   logic               xfer_st;

   spi_rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
      .req     (req_valid),
      .rr_ptr  (rr_ptr),
      .winner  (winner),
      .any_req (any_req)
   );

   // Mux the owner's byte stream; only meaningful while in XFER.
   always_comb begin
      sel_data  = '0;
      sel_valid = 1'b0;
      sel_last  = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (gnt_id == GNT_W'(i)) begin
            sel_data  = req_data[8*i +: 8];
            sel_valid = req_valid[i];
            sel_last  = req_last[i];
         end
      end
   end

   always_comb begin
      xfer_st   = (state == ST_XFER);
      out_valid = xfer_st && sel_valid;
      out_data  = xfer_st ? sel_data : 8'h00;
      req_ready = '0;
      for (int i = 0; i < NUM_REQ; i++)
         req_ready[i] = xfer_st && (gnt_id == GNT_W'(i)) && out_ready;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= ST_IDLE;
         cnt    <= '0;
         rr_ptr <= GNT_W'(NUM_REQ - 1);
         gnt_id <= '0;
         cs_n   <= '1;
         busy   <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (any_req) begin
                  gnt_id <= winner;
                  rr_ptr <= winner;
                  for (int i = 0; i < NUM_REQ; i++)
                     cs_n[i] <= (winner != GNT_W'(i));
                  busy   <= 1'b1;
                  cnt    <= CNT_W'(CS_SETUP - 1);
                  state  <= ST_SETUP;
               end
            end
            ST_SETUP: begin
               if (cnt == '0) state <= ST_XFER;
               else           cnt   <= cnt - CNT_W'(1);
            end
            ST_XFER: begin
               if (sel_valid && out_ready && sel_last) begin
                  cnt   <= CNT_W'(CS_HOLD - 1);
                  state <= ST_HOLD;
               end
            end
            ST_HOLD: begin
               if (cnt == '0) begin
                  cs_n  <= '1;
                  cnt   <= CNT_W'(CS_GAP - 1);
                  state <= ST_GAP;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            ST_GAP: begin
               if (cnt == '0) begin
                  busy  <= 1'b0;
                  state <= ST_IDLE;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_link_arbiter.sv
// Directed bench for spi_link_arbiter: per-requester byte scoreboards, grant-order
// queue, and cycle-exact checks of chip-select timing.
module tb_spi_link_arbiter;

   logic        clk;
   logic        rst;
   logic [15:0] req_data;
   logic [1:0]  req_valid;
   logic [1:0]  req_last;
   logic [1:0]  req_ready;
   logic [7:0]  out_data;
   logic        out_valid;
   logic        out_ready;
   logic [1:0]  cs_n;
   logic [1:0]  gnt_id;
   logic        busy;

   int tests_run    = 0;
   int tests_failed = 0;
   int xfer_cnt     = 0;
   logic busy_q     = 1'b0;

   logic [7:0] exp_q0[$];
   logic [7:0] exp_q1[$];
   logic [1:0] exp_gnt_q[$];

   spi_link_arbiter #(.NUM_REQ(2), .CS_SETUP(2), .CS_HOLD(2), .CS_GAP(1)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_data  (req_data),
      .req_valid (req_valid),
      .req_last  (req_last),
      .req_ready (req_ready),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .cs_n      (cs_n),
      .gnt_id    (gnt_id),
      .busy      (busy)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- checker ----------------
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // ---------------- monitor / scoreboard ----------------
   always @(negedge clk) begin
      logic [7:0] e;
      logic [1:0] g;
      if (!rst) begin
         check("cs_one_low", {31'b0, (cs_n != 2'b00)}, 32'd1);
         if (busy && !busy_q) begin
            if (exp_gnt_q.size() == 0) begin
               check("gnt_unexpected", 32'd1, 32'd0);
            end else begin
               g = exp_gnt_q.pop_front();
               check("gnt_id", {30'b0, gnt_id}, {30'b0, g});
               check("gnt_cs_n", {30'b0, cs_n}, {30'b0, ~(2'b01 << g)});
            end
         end
         if (out_valid && out_ready) begin
            xfer_cnt++;
            check("xfer_cs_n", {30'b0, cs_n}, {30'b0, ~(2'b01 << gnt_id)});
            check("xfer_ready", {30'b0, req_ready}, {30'b0, (2'b01 << gnt_id)});
            if (gnt_id == 2'd0) begin
               if (exp_q0.size() == 0) check("q0_underflow", 32'd1, 32'd0);
               else begin
                  e = exp_q0.pop_front();
                  check("data_r0", {24'b0, out_data}, {24'b0, e});
               end
            end else begin
               if (exp_q1.size() == 0) check("q1_underflow", 32'd1, 32'd0);
               else begin
                  e = exp_q1.pop_front();
                  check("data_r1", {24'b0, out_data}, {24'b0, e});
               end
            end
         end
      end
      busy_q = busy;
   end

   // ---------------- driver tasks ----------------
   task automatic push_byte(input int r, input logic [7:0] d);
      if (r == 0) exp_q0.push_back(d);
      else        exp_q1.push_back(d);
   endtask

   task automatic send_byte(input int r, input logic [7:0] d, input logic l);
      int n;
      req_data[8*r +: 8] = d;
      req_last[r]  = l;
      req_valid[r] = 1'b1;
      push_byte(r, d);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(req_ready[r] && out_ready) && n < 200);
      if (n >= 200) check("send_timeout", 32'd1, 32'd0);
      @(posedge clk); #1;
      req_valid[r] = 1'b0;
      req_last[r]  = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (busy && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 100) check("idle_timeout", 32'd1, 32'd0);
   endtask

   task automatic step();
      @(posedge clk); #1;
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int n;
      int x0;
      rst = 1'b1; req_data = '0; req_valid = '0; req_last = '0; out_ready = 1'b0;
      repeat (3) step();

      check("rst_cs_n", {30'b0, cs_n}, 32'h3);
      check("rst_busy", {31'b0, busy}, 32'h0);
      check("rst_gnt", {30'b0, gnt_id}, 32'h0);
      check("rst_out_valid", {31'b0, out_valid}, 32'h0);
      check("rst_out_data", {24'b0, out_data}, 32'h0);
      check("rst_req_ready", {30'b0, req_ready}, 32'h0);

      // 3-byte packet from requester 0 with cycle-exact CS timing
      rst = 1'b0; out_ready = 1'b1;
      req_data[7:0] = 8'hA1; req_valid[0] = 1'b1; req_last[0] = 1'b0;
      push_byte(0, 8'hA1); exp_gnt_q.push_back(2'd0);
      step();
      check("t1_cs_fall", {30'b0, cs_n}, 32'h2);
      check("t1_busy", {31'b0, busy}, 32'h1);
      check("t1_setup_valid0", {31'b0, out_valid}, 32'h0);
      step();
      check("t1_setup_valid1", {31'b0, out_valid}, 32'h0);
      step();
      check("t1_first_valid", {31'b0, out_valid}, 32'h1);
      check("t1_first_data", {24'b0, out_data}, 32'hA1);
      step();
      req_data[7:0] = 8'hA2; push_byte(0, 8'hA2);
      step();
      req_data[7:0] = 8'hA3; req_last[0] = 1'b1; push_byte(0, 8'hA3);
      step();
      req_valid[0] = 1'b0; req_last[0] = 1'b0;
      check("t1_hold_cs", {30'b0, cs_n}, 32'h2);
      check("t1_hold_valid", {31'b0, out_valid}, 32'h0);
      check("t1_hold_ready", {30'b0, req_ready}, 32'h0);
      step();
      check("t1_hold_cs2", {30'b0, cs_n}, 32'h2);
      step();
      check("t1_cs_rise", {30'b0, cs_n}, 32'h3);
      check("t1_gap_busy", {31'b0, busy}, 32'h1);
      step();
      check("t1_busy_fall", {31'b0, busy}, 32'h0);
      check("t1_xfers", xfer_cnt, 32'd3);

      // reset in the middle of a 4-byte packet from requester 1
      exp_gnt_q.push_back(2'd1);
      req_data[15:8] = 8'hB1; req_valid[1] = 1'b1; push_byte(1, 8'hB1);
      n = 0;
      do begin @(negedge clk); n++; end while (!req_ready[1] && n < 50);
      check("t2_first_accept", {31'b0, req_ready[1]}, 32'h1);
      step();
      req_data[15:8] = 8'hB2; out_ready = 1'b0;
      check("t2_mid_xfer", {31'b0, out_valid}, 32'h1);
      rst = 1'b1;
      step();
      req_valid[1] = 1'b0;
      check("t2_rst_cs", {30'b0, cs_n}, 32'h3);
      check("t2_rst_valid", {31'b0, out_valid}, 32'h0);
      check("t2_rst_busy", {31'b0, busy}, 32'h0);
      rst = 1'b0; out_ready = 1'b1;
      exp_gnt_q.push_back(2'd0); exp_gnt_q.push_back(2'd1);
      fork
         send_byte(0, 8'hC0, 1'b1);
         send_byte(1, 8'hC1, 1'b1);
      join
      wait_idle();

      // both requesters continuously valid with single-byte packets
      exp_gnt_q.push_back(2'd0); exp_gnt_q.push_back(2'd1);
      exp_gnt_q.push_back(2'd0); exp_gnt_q.push_back(2'd1);
      fork
         begin send_byte(0, 8'h10, 1'b1); send_byte(0, 8'h10, 1'b1); end
         begin send_byte(1, 8'h20, 1'b1); send_byte(1, 8'h20, 1'b1); end
      join
      wait_idle();
      check("alt_gnt_drained", exp_gnt_q.size(), 32'd0);

      // backpressure: out_ready 1,0,0,1 over a 2-byte packet
      exp_gnt_q.push_back(2'd0);
      x0 = xfer_cnt;
      req_data[7:0] = 8'h55; req_valid[0] = 1'b1; req_last[0] = 1'b0; push_byte(0, 8'h55);
      n = 0;
      do begin @(negedge clk); n++; end while (!out_valid && n < 50);
      check("bp_ready_1", {30'b0, req_ready}, 32'h1);
      check("bp_data_55", {24'b0, out_data}, 32'h55);
      step();
      req_data[7:0] = 8'hAA; req_last[0] = 1'b1; push_byte(0, 8'hAA); out_ready = 1'b0;
      @(negedge clk);
      check("bp_ready_0a", {30'b0, req_ready}, 32'h0);
      check("bp_hold_aa_a", {24'b0, out_data}, 32'hAA);
      step();
      @(negedge clk);
      check("bp_ready_0b", {30'b0, req_ready}, 32'h0);
      check("bp_hold_aa_b", {24'b0, out_data}, 32'hAA);
      step();
      out_ready = 1'b1;
      @(negedge clk);
      check("bp_ready_1b", {30'b0, req_ready}, 32'h1);
      step();
      req_valid[0] = 1'b0; req_last[0] = 1'b0;
      wait_idle();
      check("bp_xfers", xfer_cnt - x0, 32'd2);

      // requester 1 requests during requester 0's HOLD
      exp_gnt_q.push_back(2'd0); exp_gnt_q.push_back(2'd1);
      send_byte(0, 8'h33, 1'b1);
      req_data[15:8] = 8'h44; req_valid[1] = 1'b1; req_last[1] = 1'b1; push_byte(1, 8'h44);
      step();
      check("hd_hold_cs", {30'b0, cs_n}, 32'h2);
      step();
      check("hd_gap_cs", {30'b0, cs_n}, 32'h3);
      check("hd_gap_busy", {31'b0, busy}, 32'h1);
      step();
      check("hd_idle_cs", {30'b0, cs_n}, 32'h3);
      check("hd_idle_busy", {31'b0, busy}, 32'h0);
      step();
      check("hd_cs1_fall", {30'b0, cs_n}, 32'h1);
      check("hd_gnt1", {30'b0, gnt_id}, 32'h1);
      n = 0;
      do begin @(negedge clk); n++; end while (!req_ready[1] && n < 50);
      check("hd_accept", {31'b0, req_ready[1]}, 32'h1);
      step();
      req_valid[1] = 1'b0; req_last[1] = 1'b0;
      wait_idle();

      // single-byte packet
      exp_gnt_q.push_back(2'd0);
      x0 = xfer_cnt;
      send_byte(0, 8'h7E, 1'b1);
      check("sb_hold_cs", {30'b0, cs_n}, 32'h2);
      wait_idle();
      repeat (3) step();
      check("sb_xfers", xfer_cnt - x0, 32'd1);

      check("q0_empty", exp_q0.size(), 32'd0);
      check("q1_empty", exp_q1.size(), 32'd0);
      check("gnt_q_empty", exp_gnt_q.size(), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
